// File: rtl/uart_fifo_port.sv
// Buffered UART: TX and RX FIFOs around a serial framer/deframer with configurable
// word width, FIFO depth, bit period and parity. Line errors latch until cleared.
module uart_fifo_port #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [DATA_W-1:0]      i_tx_data,
   input  logic                   i_tx_push,
   output logic                   o_tx_full,
   output logic                   o_tx_busy,
   output logic [DATA_W-1:0]      o_rx_data,
   input  logic                   i_rx_pop,
   output logic                   o_rx_empty,
   output logic [$clog2(DEPTH):0] o_tx_count,
   output logic [$clog2(DEPTH):0] o_rx_count,
   input  logic                   i_uart_rx,
   output logic                   o_uart_tx,
   input  logic                   i_err_clear,
   output logic                   o_parity_err,
   output logic                   o_framing_err,
   output logic                   o_overrun_err
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_W);
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_W-1:0] r_tx_mem [DEPTH];
   logic [AW:0]       r_tx_wptr, r_tx_rptr;
   logic              w_tx_empty, w_tx_full, w_tx_wr, w_tx_rd, w_tx_tick, w_tx_line;
   logic [DATA_W-1:0] w_tx_head;
   state_t            r_tx_state, w_tx_next;
   logic [CW-1:0]     r_tx_clk;
   logic [BW-1:0]     r_tx_bit;
   logic [DATA_W-1:0] r_tx_shift;
   logic              r_tx_par, r_uart_tx;

   assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
   assign w_tx_full  = (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]) && (r_tx_wptr[AW] != r_tx_rptr[AW]);
   assign w_tx_wr    = i_tx_push && !w_tx_full;
   assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
   assign w_tx_tick  = (r_tx_clk == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk) begin
      if (w_tx_wr) r_tx_mem[r_tx_wptr[AW-1:0]] <= i_tx_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_state <= S_IDLE;
      end else begin
         if (w_tx_wr) r_tx_wptr <= r_tx_wptr + (AW+1)'(1);
         if (w_tx_rd) r_tx_rptr <= r_tx_rptr + (AW+1)'(1);
         r_tx_state <= w_tx_next;
      end
   end

   always_comb begin
      w_tx_next = r_tx_state;
      unique case (r_tx_state)
         S_IDLE:   if (!w_tx_empty) w_tx_next = S_START;
         S_START:  if (w_tx_tick) w_tx_next = S_DATA;
         S_DATA:   if (w_tx_tick && r_tx_bit == BW'(DATA_W - 1))
                      w_tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_tx_tick) w_tx_next = S_STOP;
         S_STOP:   if (w_tx_tick) w_tx_next = w_tx_empty ? S_IDLE : S_START;
         default:  w_tx_next = S_IDLE;
      endcase
   end

   // Reloading straight out of STOP gives back-to-back frames with no idle gap.
   always_comb begin
      w_tx_rd   = 1'b0;
      w_tx_line = 1'b1;
      unique case (r_tx_state)
         S_IDLE:   w_tx_rd = !w_tx_empty;
         S_START:  w_tx_line = 1'b0;
         S_DATA:   w_tx_line = r_tx_shift[0];
         S_PARITY: w_tx_line = r_tx_par;
         S_STOP:   w_tx_rd = w_tx_tick && !w_tx_empty;
         default:  w_tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_clk   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
         r_uart_tx  <= 1'b1;
      end else begin
         r_uart_tx <= w_tx_line;
         r_tx_clk  <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_clk + CW'(1);
         if (r_tx_state != S_DATA) r_tx_bit <= '0;
         else if (w_tx_tick)       r_tx_bit <= r_tx_bit + BW'(1);
         if (w_tx_rd) begin
            r_tx_shift <= w_tx_head;
            r_tx_par   <= (^w_tx_head) ^ (PARITY == 2);
         end else if (r_tx_state == S_DATA && w_tx_tick) begin
            r_tx_shift <= r_tx_shift >> 1;
         end
      end
   end

   assign o_uart_tx  = r_uart_tx;
   assign o_tx_full  = w_tx_full;
   assign o_tx_busy  = (r_tx_state != S_IDLE) || !w_tx_empty;
   assign o_tx_count = r_tx_wptr - r_tx_rptr;

   logic [DATA_W-1:0] r_rx_mem [DEPTH];
   logic [AW:0]       r_rx_wptr, r_rx_rptr;
   logic              r_rx_sync1, r_rx_sync2, r_rx_prev;
   state_t            r_rx_state, w_rx_next;
   logic [CW-1:0]     r_rx_clk;
   logic [BW-1:0]     r_rx_bit;
   logic [DATA_W-1:0] r_rx_shift, r_rx_word;
   logic              r_rx_parbit, r_rx_done, r_rx_stop_ok, r_rx_par_ok;
   logic              r_parity_err, r_framing_err, r_overrun_err;
   logic              w_rx_fall, w_rx_tick, w_rx_sample_stop, w_rx_empty, w_rx_full;
   logic              w_rx_rd, w_rx_good, w_rx_wr, w_rx_par_calc;

   assign w_rx_fall     = r_rx_prev && !r_rx_sync2;
   assign w_rx_tick     = (r_rx_state == S_START) ? (r_rx_clk == CW'(HALF - 1))
                                                  : (r_rx_clk == CW'(CLKS_PER_BIT - 1));
   assign w_rx_par_calc = (^r_rx_shift) ^ (PARITY == 2);
   assign w_rx_empty    = (r_rx_wptr == r_rx_rptr);
   assign w_rx_full     = (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]) && (r_rx_wptr[AW] != r_rx_rptr[AW]);
   assign w_rx_rd       = i_rx_pop && !w_rx_empty;
   assign w_rx_good     = r_rx_done && r_rx_stop_ok && r_rx_par_ok;
   assign w_rx_wr       = w_rx_good && (!w_rx_full || w_rx_rd);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= S_IDLE;
      end else begin
         r_rx_sync1 <= i_uart_rx;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_prev  <= r_rx_sync2;
         r_rx_state <= w_rx_next;
      end
   end

   always_comb begin
      w_rx_next = r_rx_state;
      unique case (r_rx_state)
         S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
         S_START:  if (w_rx_tick) w_rx_next = r_rx_sync2 ? S_IDLE : S_DATA;
         S_DATA:   if (w_rx_tick && r_rx_bit == BW'(DATA_W - 1))
                      w_rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_rx_tick) w_rx_next = S_STOP;
         S_STOP:   if (w_rx_tick) w_rx_next = S_IDLE;
         default:  w_rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rx_sample_stop = (r_rx_state == S_STOP) && w_rx_tick;
   end

   // The counter preloads 1 in IDLE so the edge-detect cycle counts toward the half-bit wait.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_clk     <= '0;
         r_rx_bit     <= '0;
         r_rx_shift   <= '0;
         r_rx_parbit  <= 1'b0;
         r_rx_done    <= 1'b0;
         r_rx_stop_ok <= 1'b0;
         r_rx_par_ok  <= 1'b0;
         r_rx_word    <= '0;
      end else begin
         if (r_rx_state == S_IDLE) r_rx_clk <= CW'(1);
         else if (w_rx_tick)       r_rx_clk <= '0;
         else                      r_rx_clk <= r_rx_clk + CW'(1);
         if (r_rx_state != S_DATA) r_rx_bit <= '0;
         else if (w_rx_tick)       r_rx_bit <= r_rx_bit + BW'(1);
         if (r_rx_state == S_DATA && w_rx_tick)
            r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_W-1:1]};
         if (r_rx_state == S_PARITY && w_rx_tick) r_rx_parbit <= r_rx_sync2;
         r_rx_done <= w_rx_sample_stop;
         if (w_rx_sample_stop) begin
            r_rx_stop_ok <= r_rx_sync2;
            r_rx_par_ok  <= (PARITY == 0) || (w_rx_par_calc == r_rx_parbit);
            r_rx_word    <= r_rx_shift;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_rx_wr) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_word;
   end

   // A new error outranks err_clear arriving in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_wptr     <= '0;
         r_rx_rptr     <= '0;
         r_parity_err  <= 1'b0;
         r_framing_err <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         if (w_rx_wr) r_rx_wptr <= r_rx_wptr + (AW+1)'(1);
         if (w_rx_rd) r_rx_rptr <= r_rx_rptr + (AW+1)'(1);
         r_framing_err <= (r_rx_done && !r_rx_stop_ok) || (r_framing_err && !i_err_clear);
         r_parity_err  <= (r_rx_done && r_rx_stop_ok && !r_rx_par_ok) || (r_parity_err && !i_err_clear);
         r_overrun_err <= (w_rx_good && w_rx_full && !w_rx_rd) || (r_overrun_err && !i_err_clear);
      end
   end

   assign o_rx_empty    = w_rx_empty;
   assign o_rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr[AW-1:0]];
   assign o_rx_count    = r_rx_wptr - r_rx_rptr;
   assign o_parity_err  = r_parity_err;
   assign o_framing_err = r_framing_err;
   assign o_overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port: a looped-back PARITY=0 port plus a PARITY=1 port
// fed from an injected serial line.
module tb_uart_fifo_port;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] txData;
   logic       txPush, rxPop, errClear, injectLine, useLoop;

   logic       txFull, txBusy, rxEmpty, uartTx, parityErr, framingErr, overrunErr;
   logic [7:0] rxData;
   logic [2:0] txCount, rxCount;
   logic       rxLine;

   logic       p1TxFull, p1TxBusy, p1RxEmpty, p1UartTx, p1ParityErr, p1FramingErr, p1OverrunErr;
   logic [7:0] p1RxData;
   logic [2:0] p1TxCount, p1RxCount;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t        vecs [4];
   logic [9:0]  leadFrames [5];
   logic [9:0]  gotFrame;
   logic [49:0] stream;
   logic        seenLow;

   always #5 clk = ~clk;

   assign rxLine = useLoop ? uartTx : injectLine;

   uart_fifo_port #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(0)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_tx_data(txData), .i_tx_push(txPush),
      .o_tx_full(txFull), .o_tx_busy(txBusy), .o_rx_data(rxData), .i_rx_pop(rxPop),
      .o_rx_empty(rxEmpty), .o_tx_count(txCount), .o_rx_count(rxCount),
      .i_uart_rx(rxLine), .o_uart_tx(uartTx), .i_err_clear(errClear),
      .o_parity_err(parityErr), .o_framing_err(framingErr), .o_overrun_err(overrunErr)
   );

   uart_fifo_port #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(1)) dutPar (
      .i_clk(clk), .i_rst_n(rstN), .i_tx_data(8'h00), .i_tx_push(1'b0),
      .o_tx_full(p1TxFull), .o_tx_busy(p1TxBusy), .o_rx_data(p1RxData), .i_rx_pop(1'b0),
      .o_rx_empty(p1RxEmpty), .o_tx_count(p1TxCount), .o_rx_count(p1RxCount),
      .i_uart_rx(injectLine), .o_uart_tx(p1UartTx), .i_err_clear(errClear),
      .o_parity_err(p1ParityErr), .o_framing_err(p1FramingErr), .o_overrun_err(p1OverrunErr)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      txData = d;
      txPush = 1'b1;
      @(negedge clk);
      txPush = 1'b0;
   endtask

   task automatic injectFrame(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         injectLine = bits[i];
         repeat (CPB) @(negedge clk);
      end
      injectLine = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic pulseErrClear();
      errClear = 1'b1;
      @(negedge clk);
      errClear = 1'b0;
   endtask

   task automatic popOne();
      rxPop = 1'b1;
      @(negedge clk);
      rxPop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, frame: 10'h34A};
      vecs[1] = '{data: 8'h00, frame: 10'h200};
      vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
      vecs[3] = '{data: 8'h3C, frame: 10'h278};
      leadFrames[0] = 10'h2B4;
      leadFrames[1] = 10'h202;
      leadFrames[2] = 10'h204;
      leadFrames[3] = 10'h206;
      leadFrames[4] = 10'h208;

      rstN = 1'b0; txData = 8'h00; txPush = 1'b0; rxPop = 1'b0;
      errClear = 1'b0; injectLine = 1'b1; useLoop = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("reset_uart_tx", uartTx, 1);
      checkOutput("reset_tx_full_busy", {txFull, txBusy}, 0);
      checkOutput("reset_rx_empty", rxEmpty, 1);
      checkOutput("reset_counts", {txCount, rxCount}, 0);
      checkOutput("reset_errors", {parityErr, framingErr, overrunErr}, 0);
      checkOutput("reset_rx_data", rxData, 0);
      checkOutput("reset_par_port", {p1UartTx, p1RxEmpty, p1TxBusy, p1TxFull, p1TxCount, p1RxCount, p1OverrunErr}, 11'b110_0000_0000);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] single frames through loopback");
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].data);
         checkOutput("tx_count_at_push", txCount, 1);
         @(negedge clk);
         checkOutput("tx_line_before_start", uartTx, 1);
         checkOutput("tx_busy_after_load", txBusy, 1);
         @(negedge clk);
         gotFrame[0] = uartTx;
         for (int j = 1; j < 10; j++) begin
            repeat (CPB) @(negedge clk);
            gotFrame[j] = uartTx;
         end
         checkOutput($sformatf("tx_frame_%0h", vecs[v].data), gotFrame, vecs[v].frame);
         repeat (4) @(negedge clk);
         checkOutput("rx_empty_before_write", rxEmpty, 1);
         repeat (4) @(negedge clk);
         checkOutput("rx_empty_after_frame", rxEmpty, 0);
         checkOutput($sformatf("rx_data_%0h", vecs[v].data), rxData, vecs[v].data);
         checkOutput("rx_count_one", rxCount, 1);
         popOne();
         checkOutput("rx_empty_after_pop", rxEmpty, 1);
      end

      $display("[TB] burst of pushes while a frame is on the line");
      applyStimulus(8'h5A);
      repeat (2) @(negedge clk);
      checkOutput("lead_start_bit", uartTx, 0);
      fork
         begin
            for (int j = 0; j < 50; j++) begin
               if (j > 0) repeat (CPB) @(negedge clk);
               stream[j] = uartTx;
            end
         end
         begin
            for (int i = 0; i < 5; i++) begin
               txData = 8'(i + 1);
               txPush = 1'b1;
               @(negedge clk);
               if (i == 3) begin
                  checkOutput("tx_full_after_fourth", txFull, 1);
                  checkOutput("tx_count_after_fourth", txCount, 4);
               end
            end
            txPush = 1'b0;
            checkOutput("tx_count_fifth_ignored", txCount, 4);
            for (int k = 0; k < 80 && rxEmpty; k++) @(negedge clk);
            checkOutput("lead_rx_arrived", rxEmpty, 0);
            checkOutput("lead_rx_data", rxData, 8'h5A);
            popOne();
         end
      join
      for (int k = 0; k < 5; k++)
         checkOutput($sformatf("burst_frame_%0d", k), stream[10*k +: 10], leadFrames[k]);
      for (int k = 0; k < 40 && rxCount != 3'd4; k++) @(negedge clk);
      checkOutput("rx_count_four", rxCount, 4);
      checkOutput("rx_head_first_word", rxData, 8'h01);
      checkOutput("tx_idle_after_burst", {txBusy, txFull, txCount}, 0);

      $display("[TB] overrun on full RX FIFO");
      applyStimulus(8'h77);
      repeat (46) @(negedge clk);
      checkOutput("overrun_set", overrunErr, 1);
      checkOutput("overrun_head_kept", rxData, 8'h01);
      checkOutput("overrun_count_kept", rxCount, 4);
      checkOutput("overrun_other_flags", {parityErr, framingErr}, 0);
      pulseErrClear();
      checkOutput("overrun_cleared", overrunErr, 0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("drain_word_%0d", k), rxData, k + 1);
         popOne();
      end
      checkOutput("drained_empty", rxEmpty, 1);

      $display("[TB] parity port");
      injectFrame(16'h040E, 11);
      checkOutput("parity_err_set", p1ParityErr, 1);
      checkOutput("parity_word_dropped", p1RxEmpty, 1);
      pulseErrClear();
      checkOutput("parity_err_cleared", p1ParityErr, 0);
      injectFrame(16'h060E, 11);
      checkOutput("parity_good_accepted", p1RxEmpty, 0);
      checkOutput("parity_good_data", p1RxData, 8'h07);
      checkOutput("parity_good_no_err", {p1ParityErr, p1FramingErr}, 0);

      $display("[TB] framing error and glitch");
      useLoop = 1'b0;
      injectFrame(16'h0078, 10);
      checkOutput("framing_err_set", framingErr, 1);
      checkOutput("framing_word_dropped", rxEmpty, 1);
      pulseErrClear();
      checkOutput("framing_err_cleared", framingErr, 0);
      injectLine = 1'b0;
      @(negedge clk);
      injectLine = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("glitch_no_error", {parityErr, framingErr, overrunErr}, 0);
      checkOutput("glitch_no_word", rxEmpty, 1);
      injectFrame(16'h0278, 10);
      checkOutput("after_glitch_rx", rxEmpty, 0);
      checkOutput("after_glitch_data", rxData, 8'h3C);
      popOne();
      useLoop = 1'b1;

      $display("[TB] reset mid-frame");
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      checkOutput("queued_two", txCount, 2);
      repeat (14) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("reset_async_tx_line", uartTx, 1);
      checkOutput("reset_async_tx_count", txCount, 0);
      checkOutput("reset_async_busy", txBusy, 0);
      @(negedge clk);
      rstN = 1'b1;
      seenLow = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (!uartTx) seenLow = 1'b1;
      end
      checkOutput("no_frame_after_reset", seenLow, 0);
      checkOutput("idle_after_reset", {txBusy, rxEmpty}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
